// File: rtl/ifp_serial_pe.sv
// ============================================================================
// Module   : ifp_serial_pe
// Purpose  : Bit-serial IFT pixel element that evaluates one neighbour offer
//            per run using f_sum or f_max, with a serial load/unload chain.
//            Optional macro IFP_LIFO_TIE_EN makes equal-cost offers conquer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ifp_serial_pe #(
  parameter int COST_W  = 8,
  parameter int LABEL_W = 8,
  parameter int PRED_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              pathfunction,
  input  logic [PRED_W-1:0] nbr_dir,
  input  logic              nbr_cost_in,
  input  logic              arc_in,
  input  logic              nbr_label_in,
  input  logic              shift_en,
  input  logic              ser_in,
  output logic              ser_out,
  input  logic              clear_changed,
  output logic              busy,
  output logic              done,
  output logic              conquest,
  output logic              changed,
  output logic [COST_W-1:0] cost_out
);

  localparam int T     = COST_W + LABEL_W + PRED_W + 2;
  localparam int MAXW  = (COST_W > LABEL_W) ? COST_W : LABEL_W;
  localparam int CNT_W = (MAXW > 1) ? $clog2(MAXW) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COST   = 3'd1,
    S_LABEL  = 3'd2,
    S_DECIDE = 3'd3,
    S_SAVE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [COST_W-1:0]   cost_q, cost_d;
  logic [LABEL_W-1:0]  label_q, label_d;
  logic [PRED_W-1:0]   pred_q, pred_d;
  logic                seed_q, seed_d;
  logic                changed_q, changed_d;
  logic [COST_W-1:0]   nbr_q, nbr_d;
  logic [COST_W-1:0]   arc_q, arc_d;
  logic [COST_W-1:0]   sum_q, sum_d;
  logic [LABEL_W-1:0]  lab_hold_q, lab_hold_d;
  logic                carry_q, carry_d;
  logic                gt_q, gt_d;
  logic                pf_q, pf_d;
  logic [PRED_W-1:0]   dir_q, dir_d;
  logic                conq_q, conq_d;
  logic                done_q, done_d;

  logic [T-1:0]        w_chain_cur;
  logic [T-1:0]        w_chain_nxt;
  logic [COST_W-1:0]   w_cand;
  logic                w_win;

  // A clear in the same cycle as a shift takes effect first.
  assign w_chain_cur = {changed_q & ~clear_changed, seed_q, pred_q, label_q, cost_q};
  assign w_chain_nxt = {ser_in, w_chain_cur[T-1:1]};

  always_comb begin
    w_cand = '0;
    if (pf_q) begin
      w_cand = gt_q ? nbr_q : arc_q;
    end else begin
      w_cand = carry_q ? {COST_W{1'b1}} : sum_q;
    end
  end

`ifdef IFP_LIFO_TIE_EN
  assign w_win = (w_cand <= cost_q) & ~seed_q;
`else
  assign w_win = (w_cand < cost_q) & ~seed_q;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cost_d     = cost_q;
    label_d    = label_q;
    pred_d     = pred_q;
    seed_d     = seed_q;
    changed_d  = changed_q;
    nbr_d      = nbr_q;
    arc_d      = arc_q;
    sum_d      = sum_q;
    lab_hold_d = lab_hold_q;
    carry_d    = carry_q;
    gt_d       = gt_q;
    pf_d       = pf_q;
    dir_d      = dir_q;
    conq_d     = conq_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (shift_en) begin
          {changed_d, seed_d, pred_d, label_d, cost_d} = w_chain_nxt;
        end else begin
          if (clear_changed) begin
            changed_d = 1'b0;
          end
          if (start) begin
            pf_d    = pathfunction;
            dir_d   = nbr_dir;
            conq_d  = 1'b0;
            carry_d = 1'b0;
            gt_d    = 1'b0;
            cnt_d   = '0;
            state_d = S_COST;
          end
        end
      end
      S_COST: begin
        nbr_d   = {nbr_cost_in, nbr_q[COST_W-1:1]};
        arc_d   = {arc_in, arc_q[COST_W-1:1]};
        sum_d   = {nbr_cost_in ^ arc_in ^ carry_q, sum_q[COST_W-1:1]};
        carry_d = (nbr_cost_in & arc_in) | (carry_q & (nbr_cost_in ^ arc_in));
        gt_d    = (nbr_cost_in & ~arc_in) | (~(nbr_cost_in ^ arc_in) & gt_q);
        if (cnt_q == CNT_W'(COST_W - 1)) begin
          cnt_d   = '0;
          state_d = S_LABEL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LABEL: begin
        lab_hold_d = lab_hold_q >> 1;
        lab_hold_d[LABEL_W-1] = nbr_label_in;
        if (cnt_q == CNT_W'(LABEL_W - 1)) begin
          cnt_d   = '0;
          state_d = S_DECIDE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECIDE: begin
        conq_d  = w_win;
        state_d = S_SAVE;
      end
      S_SAVE: begin
        if (conq_q) begin
          cost_d    = w_cand;
          label_d   = lab_hold_q;
          pred_d    = dir_q;
          changed_d = 1'b1;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cost_q     <= {COST_W{1'b1}};
      label_q    <= '0;
      pred_q     <= '0;
      seed_q     <= 1'b0;
      changed_q  <= 1'b0;
      nbr_q      <= '0;
      arc_q      <= '0;
      sum_q      <= '0;
      lab_hold_q <= '0;
      carry_q    <= 1'b0;
      gt_q       <= 1'b0;
      pf_q       <= 1'b0;
      dir_q      <= '0;
      conq_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cost_q     <= cost_d;
      label_q    <= label_d;
      pred_q     <= pred_d;
      seed_q     <= seed_d;
      changed_q  <= changed_d;
      nbr_q      <= nbr_d;
      arc_q      <= arc_d;
      sum_q      <= sum_d;
      lab_hold_q <= lab_hold_d;
      carry_q    <= carry_d;
      gt_q       <= gt_d;
      pf_q       <= pf_d;
      dir_q      <= dir_d;
      conq_q     <= conq_d;
      done_q     <= done_d;
    end
  end

  assign ser_out  = cost_q[0];
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign conquest = conq_q;
  assign changed  = changed_q;
  assign cost_out = cost_q;

endmodule

`default_nettype wire
